uart_tx_io: RTL and testbench
=============================

UART_TX_IO -- requirements
Module: uart_tx_io

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port io_wstrb  input  1  one-cycle pulse: processor store to the UART data word.
REQ-006 Port io_wdata  input  32  store data; only bits [7:0] are used.
REQ-007 Port io_rstrb  input  1  one-cycle pulse: processor load from the UART status word.
REQ-008 Port io_rdata  output  32  registered status word.
REQ-009 Port busy  output  1  high while a frame is in flight.
REQ-010 Port TXD  output  1  serial line, idle high.

Function
REQ-011 The bit period SHALL be CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division), held in a counter sized to hold CLKS_PER_BIT-1.
- Elaboration SHALL fail if CLKS_PER_BIT < 2.
REQ-012 The frame SHALL be 8N1: one start bit (0), data bits [0] through [7] LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP.
- IDLE->START on io_wstrb.
- START->DATA after one bit period.
- DATA->STOP after the 8th bit period.
- STOP->IDLE after one bit period.
REQ-014 On io_wstrb in IDLE at edge N:
- io_wdata[7:0] SHALL be latched into the shift register.
- TXD SHALL be 0 and busy SHALL be 1 from edge N onward (first cycle after edge N).
REQ-015 The full frame SHALL occupy exactly 10*CLKS_PER_BIT cycles, measured from edge N to the edge that returns the FSM to IDLE; busy SHALL drop at that edge.
REQ-016 io_wstrb while busy=1 SHALL be ignored: the data is dropped and the frame in flight is unaffected, including a strobe in the last STOP cycle.
REQ-017 TXD SHALL be driven directly from a flop, never from combinational logic.
REQ-018 On io_rstrb at edge N, io_rdata SHALL load {22'b0, busy, 9'b0} (bit 9 = busy sampled before edge N), giving one cycle of read latency.
- io_rdata SHALL hold its value when io_rstrb=0.
REQ-019 io_wstrb and io_rstrb asserted in the same cycle SHALL both be honoured; the status read returns busy=0 when starting from IDLE.
REQ-020 The bit counter SHALL reload to 0 at every bit boundary, with no cumulative drift over a frame.

Reset
REQ-021 While reset=1, and asynchronously on its assertion:
- state = IDLE
- TXD = 1
- busy = 0
- io_rdata = 0
- baud counter = 0
- bit index = 0
- shift register = 0
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, with TXD=1 within the same cycle and no glitch low.
REQ-023 After reset deasserts, the first io_wstrb SHALL start a complete, correct frame.

Verification
REQ-024 CLK_FREQ_HZ=1000, BAUD_RATE=100 (10 clk/bit), write 0x000000A5 -> TXD holds 0, 1,0,1,0,0,1,0,1, then 1, each for 10 cycles; busy high for exactly 100 cycles.
REQ-025 Same config, write 0x55 then write 0xFF 37 cycles later -> serial byte is 0x55 only; the second write is dropped and line idle after 100 cycles.
REQ-026 io_rstrb mid-frame -> io_rdata=0x00000200 next cycle; io_rstrb after frame end -> io_rdata=0x00000000.
REQ-027 Reset pulse at cycle 45 of a frame -> TXD=1 and busy=0 immediately; a subsequent write of 0x3C transmits correctly.
REQ-028 Back-to-back: write 0x01, poll until busy=0, write 0x80 on the next cycle -> two contiguous frames, each 100 cycles, with at least one idle-high cycle between them.

Source files
------------

// File: rtl/uart_tx_io.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_io
//  Purpose  : Memory-mapped 8N1 UART transmitter with a registered status word
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_io #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wstrb,
    input  logic [31:0] io_wdata,
    input  logic        io_rstrb,
    output logic [31:0] io_rdata,
    output logic        busy,
    output logic        TXD
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_CNT_W        = (c_CLKS_PER_BIT > 2) ? $clog2(c_CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    generate
        if (c_CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_io: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_txd;
    logic               r_busy;
    logic [31:0]        r_rdata;
    logic               w_bit_end;
    logic               w_unused_wdata;

    assign w_bit_end      = (r_baud_cnt == c_CNT_LAST);
    assign w_unused_wdata = &{1'b0, io_wdata[31:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            // Status reflects busy as it was before this edge.
            if (io_rstrb) begin
                r_rdata <= {22'b0, r_busy, 9'b0};
            end

            case (r_state)
                c_S_IDLE: begin
                    if (io_wstrb) begin
                        r_shift    <= io_wdata[7:0];
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= c_S_START;
                    end
                end
                c_S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_txd      <= r_shift[0];
                        r_state    <= c_S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_txd     <= 1'b1;
                            r_state   <= c_S_STOP;
                        end else begin
                            // Next line value is the bit about to become LSB.
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= c_S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TXD      = r_txd;
    assign busy     = r_busy;
    assign io_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_io
//  Purpose  : Self-checking bench for uart_tx_io at 10 clocks per bit
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_io;

    localparam int c_BIT   = 10;
    localparam int c_FRAME = 10 * c_BIT;

    logic        clk;
    logic        reset;
    logic        io_wstrb;
    logic [31:0] io_wdata;
    logic        io_rstrb;
    logic [31:0] io_rdata;
    logic        busy;
    logic        TXD;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_rdata;

    uart_tx_io #(
        .CLK_FREQ_HZ (1000),
        .BAUD_RATE   (100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .io_wstrb (io_wstrb),
        .io_wdata (io_wdata),
        .io_rstrb (io_rstrb),
        .io_rdata (io_rdata),
        .busy     (busy),
        .TXD      (TXD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles after the start edge of a frame carrying d.
    function automatic logic line_level(input logic [7:0] d, input int k);
        int slot;
        slot = k / c_BIT;
        if (slot == 0)      return 1'b0;
        else if (slot <= 8) return d[slot-1];
        else                return 1'b1;
    endfunction

    // Sends one frame and checks every cycle. drop_at / rd_at: cycle index of an
    // extra write / status read during the frame (-1 for none).
    task automatic send_frame(input logic [7:0] d, input int drop_at, input int rd_at,
                              input bit rd_with_start);
        logic [31:0] pend;
        bit          rd_now;
        io_wdata = $urandom();
        io_wdata[7:0] = d;
        io_wstrb = 1'b1;
        io_rstrb = rd_with_start;
        tick();
        io_wstrb = 1'b0;
        io_rstrb = 1'b0;
        if (rd_with_start) begin
            exp_rdata = 32'h0;
            check("rdata_with_start", io_rdata, exp_rdata);
        end
        for (int k = 0; k < c_FRAME; k++) begin
            check($sformatf("txd_%02h_k%0d", d, k), {31'b0, TXD}, {31'b0, line_level(d, k)});
            check($sformatf("busy_%02h_k%0d", d, k), {31'b0, busy}, 32'h1);
            check($sformatf("rdata_%02h_k%0d", d, k), io_rdata, exp_rdata);
            rd_now = (k == rd_at);
            pend = 32'h0000_0200;
            if (k == drop_at) begin
                io_wstrb = 1'b1;
                io_wdata = $urandom();
            end
            io_rstrb = rd_now;
            tick();
            io_wstrb = 1'b0;
            io_rstrb = 1'b0;
            if (rd_now) exp_rdata = pend;
        end
        check($sformatf("end_busy_%02h", d), {31'b0, busy}, 32'h0);
        check($sformatf("end_txd_%02h", d), {31'b0, TXD}, 32'h1);
        check($sformatf("end_rdata_%02h", d), io_rdata, exp_rdata);
    endtask

    task automatic idle_checks(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({tag, "_idle_txd"}, {31'b0, TXD}, 32'h1);
            check({tag, "_idle_busy"}, {31'b0, busy}, 32'h0);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_rdata = 32'h0;
        reset     = 1'b1;
        io_wstrb  = 1'b0;
        io_wdata  = 32'h0;
        io_rstrb  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_txd", {31'b0, TXD}, 32'h1);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_rdata", io_rdata, 32'h0);
        reset = 1'b0;
        tick();

        // Reference frame 0xA5
        send_frame(8'hA5, -1, -1, 1'b0);
        idle_checks("a5", 2);

        // 0x55 with a dropped 0xFF write 37 cycles later
        send_frame(8'h55, 37, -1, 1'b0);
        idle_checks("drop37", 5);

        // Status read mid-frame, then after the frame ends
        send_frame(8'hC3, 50, 42, 1'b0);
        io_rstrb = 1'b1;
        tick();
        io_rstrb = 1'b0;
        exp_rdata = 32'h0;
        check("rdata_after_frame", io_rdata, exp_rdata);
        tick();
        check("rdata_hold", io_rdata, exp_rdata);

        // Write and read in the same idle cycle
        send_frame(8'h3A, -1, 10, 1'b1);
        tick();

        // Randomised frames with stray writes (one in the last STOP cycle)
        for (int f = 0; f < 6; f++) begin
            send_frame(8'($urandom()), (f == 0) ? c_FRAME - 1 : int'($urandom_range(0, c_FRAME - 1)),
                       int'($urandom_range(0, c_FRAME - 1)), 1'b0);
            idle_checks("rand", 2);
        end

        // Reset pulse mid-frame at cycle 45
        io_wdata = 32'h0000_00E7;
        io_wstrb = 1'b1;
        io_rstrb = 1'b1;
        tick();
        io_wstrb = 1'b0;
        io_rstrb = 1'b0;
        repeat (45) tick();
        #2;
        reset = 1'b1;
        #1;
        exp_rdata = 32'h0;
        check("midrst_txd", {31'b0, TXD}, 32'h1);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_rdata", io_rdata, 32'h0);
        tick();
        check("midrst_hold_txd", {31'b0, TXD}, 32'h1);
        #3;
        reset = 1'b0;
        tick();
        send_frame(8'h3C, -1, -1, 1'b0);

        // Back-to-back: write 0x80 on the cycle after busy is seen low
        send_frame(8'h01, -1, -1, 1'b0);
        send_frame(8'h80, -1, -1, 1'b0);
        idle_checks("b2b", 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
